// File: rtl/sum_recover_pkg.sv
// Shared constants, state encoding and slice-count helper for the sum/operand
// recovery path; the adder side uses the same WIDTH/DIGIT defaults.
package sum_recover_pkg;

    localparam int WIDTH_DEF = 12;
    localparam int DIGIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slices needed to cover a (width+1)-bit sum, i.e. ceil((width+1)/digit).
    function automatic int calc_ndig(input int width, input int digit);
        return (width + digit) / digit;
    endfunction

endpackage

// File: rtl/sum_operand_recover_digit_sub.sv
// One DIGIT-bit subtract slice with borrow; reused every cycle by the top level.
module digit_sub
    import sum_recover_pkg::*;
#(
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_borrow,
    output logic [DIGIT-1:0] o_diff,
    output logic             o_borrow
);

    logic [DIGIT:0] w_full;

    // The extra top bit of the (DIGIT+1)-bit difference is the borrow-out.
    assign w_full   = (DIGIT+1)'(i_a) - (DIGIT+1)'(i_b) - (DIGIT+1)'(i_borrow);
    assign o_diff   = w_full[DIGIT-1:0];
    assign o_borrow = w_full[DIGIT];

endmodule

// File: rtl/sum_operand_recover.sv
// Recovers B = S - A from a (WIDTH+1)-bit sum and one operand, one DIGIT-bit
// slice per cycle, with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | ready for a request, operands captured on accept
// CALC  | one slice subtracted per cycle, borrow carried in r_borrow
// DONE  | result presented until the consumer takes it
module sum_operand_recover
    import sum_recover_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH:0]   i_in_sum,
    input  logic [WIDTH-1:0] i_in_a,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_b,
    output logic             o_out_err
);

    localparam int NDIG = calc_ndig(WIDTH, DIGIT);
    localparam int EXT  = NDIG * DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [EXT-1:0]    r_s;
    logic [EXT-1:0]    r_a;
    logic [EXT-1:0]    r_res;
    logic [IDXW-1:0]   r_idx;
    logic              r_borrow;

    logic              w_accept;
    logic              w_last;
    logic [DIGIT-1:0]  w_s_dig;
    logic [DIGIT-1:0]  w_a_dig;
    logic [DIGIT-1:0]  w_diff;
    logic              w_borrow_out;

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_last      = (r_idx == LAST_IDX);

    assign w_s_dig = r_s[r_idx*DIGIT +: DIGIT];
    assign w_a_dig = r_a[r_idx*DIGIT +: DIGIT];

    digit_sub #(.DIGIT(DIGIT)) u_digit_sub (
        .i_a      (w_s_dig),
        .i_b      (w_a_dig),
        .i_borrow (r_borrow),
        .o_diff   (w_diff),
        .o_borrow (w_borrow_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = CALC;
            CALC:    if (w_last)      w_state_nxt = DONE;
            DONE:    if (i_out_ready) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s      <= '0;
            r_a      <= '0;
            r_res    <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_s      <= EXT'(i_in_sum);
            r_a      <= EXT'(i_in_a);
            r_res    <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == CALC) begin
            r_res[r_idx*DIGIT +: DIGIT] <= w_diff;
            r_borrow <= w_borrow_out;
            r_idx    <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Final borrow flags S < A; any set bit above WIDTH flags S - A >= 2^WIDTH.
    assign o_out_b   = r_res[WIDTH-1:0];
    assign o_out_err = r_borrow | (|r_res[EXT-1:WIDTH]);

endmodule

// File: tb/tb_sum_operand_recover.sv
// Directed-vector and randomized checks for sum_operand_recover at the defaults.
module tb_sum_operand_recover;

    typedef struct {
        logic [12:0] s;
        logic [11:0] a;
        logic [11:0] b;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_sum = '0;
    logic [11:0] in_a = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_b;
    logic        out_err;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs[13];

    sum_operand_recover dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_sum    (in_sum),
        .i_in_a      (in_a),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_b     (out_b),
        .o_out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!in_ready && t < 32) begin
            @(negedge clk);
            t++;
        end
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Present one request at a negedge; returns at the negedge after the accepting edge.
    task automatic accept(input logic [12:0] s, input logic [11:0] a);
        in_valid = 1'b1;
        in_sum   = s;
        in_a     = a;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sum   = 13'($urandom);
        in_a     = 12'($urandom);
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        out_ready = 1'b1;
        wait_ready(name);
        accept(v.s, v.a);
        wait_valid(name, lat);
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " out_b"}, 32'(out_b), 32'(v.b));
        check({name, " out_err"}, 32'(out_err), 32'(v.err));
        @(negedge clk);
        check({name, " valid_after_hs"}, 32'(out_valid), 32'd0);
        check({name, " ready_after_hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        vec_t v;

        vecs[0]  = '{13'h1000, 12'h001, 12'hFFF, 1'b0};
        vecs[1]  = '{13'h1FFE, 12'hFFF, 12'hFFF, 1'b0};
        vecs[2]  = '{13'h0005, 12'h007, 12'hFFE, 1'b1};
        vecs[3]  = '{13'h1FFF, 12'h000, 12'hFFF, 1'b1};
        vecs[4]  = '{13'h0ABC, 12'hABC, 12'h000, 1'b0};
        vecs[5]  = '{13'h0000, 12'h000, 12'h000, 1'b0};
        vecs[6]  = '{13'h0064, 12'h028, 12'h03C, 1'b0};
        vecs[7]  = '{13'h0FFF, 12'h001, 12'hFFE, 1'b0};
        vecs[8]  = '{13'h1000, 12'h000, 12'h000, 1'b1};
        vecs[9]  = '{13'h0000, 12'h001, 12'hFFF, 1'b1};
        vecs[10] = '{13'h1234, 12'h234, 12'h000, 1'b1};
        vecs[11] = '{13'h1800, 12'hFFF, 12'h801, 1'b0};
        vecs[12] = '{13'h0FFF, 12'hFFF, 12'h000, 1'b0};

        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_b", 32'(out_b), 32'd0);
        check("reset out_err", 32'(out_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: hold out_ready low with a second request waiting.
        out_ready = 1'b0;
        wait_ready("bp1");
        accept(13'h0FA0, 12'h123);
        in_valid = 1'b1;
        in_sum   = 13'h1005;
        in_a     = 12'h010;
        wait_valid("bp1", lat);
        check("bp1 latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            check("bp hold out_b", 32'(out_b), 32'h0E7D);
            check("bp hold out_err", 32'(out_err), 32'd0);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
            check("bp hold out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp valid_after_hs", 32'(out_valid), 32'd0);
        check("bp ready_after_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp2 accepted", 32'(in_ready), 32'd0);
        wait_valid("bp2", lat);
        check("bp2 latency", 32'(lat), 32'd4);
        check("bp2 out_b", 32'(out_b), 32'h0FF5);
        check("bp2 out_err", 32'(out_err), 32'd0);
        @(negedge clk);

        // Asynchronous reset two cycles into CALC.
        out_ready = 1'b1;
        wait_ready("rst");
        accept(13'h0100, 12'h001);
        @(negedge clk);
        @(negedge clk);
        check("rst pre in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rst mid out_valid", 32'(out_valid), 32'd0);
        check("rst mid in_ready", 32'(in_ready), 32'd1);
        check("rst mid out_b", 32'(out_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst no emit", 32'(out_valid), 32'd0);
        v = '{13'h0064, 12'h028, 12'h03C, 1'b0};
        run_vec("post_rst", v);

        // Randomized sweep against an integer reference model.
        for (int t = 0; t < 1000; t++) begin
            logic [12:0] s;
            logic [11:0] a;
            logic [31:0] dv;
            int          d;
            int          hold;
            logic        e_err;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s = 13'($urandom);
            a = ($urandom_range(0, 7) == 0) ? s[11:0] : 12'($urandom);
            d = int'(s) - int'(a);
            dv = d;
            e_err = (d < 0) || (d >= 4096);
            out_ready = 1'($urandom_range(0, 1));
            wait_ready("rnd");
            accept(s, a);
            wait_valid("rnd", lat);
            check("rnd latency", 32'(lat), 32'd4);
            check($sformatf("rnd%0d out_b s=%0h a=%0h", t, s, a), 32'(out_b), 32'(dv[11:0]));
            check($sformatf("rnd%0d out_err s=%0h a=%0h", t, s, a), 32'(out_err), 32'(e_err));
            if (!out_ready) begin
                hold = $urandom_range(0, 3);
                repeat (hold) @(negedge clk);
                out_ready = 1'b1;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sum_operand_recover.md
# sum_operand_recover

Multi-cycle inverse of the 12-bit sum datapath: given a (WIDTH+1)-bit sum S and one WIDTH-bit operand A, it recovers the other operand B = S − A. The subtraction runs digit-serially, one DIGIT-bit slice per cycle with a registered borrow chain, so the block stays small. Transactions use valid/ready handshakes on both sides. The block sits downstream of the adder in checker and decode paths, where sums are reconciled back to operands.

## Interface
- WIDTH, 12, operand width; the sum is WIDTH+1 bits
- DIGIT, 4, bits subtracted per cycle; must divide into ceil((WIDTH+1)/DIGIT) slices
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous and active-high
- in_valid  in  1  request holds a valid sum/operand pair
- in_ready  out  1  block can accept a request
- in_sum  in  WIDTH+1  sum S
- in_a  in  WIDTH  known operand A
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_b  out  WIDTH  recovered operand, equal to (S − A) mod 2^WIDTH
- out_err  out  1  S < A, or S − A ≥ 2^WIDTH

## Operation
- NDIG = ceil((WIDTH+1)/DIGIT), which is 4 at the defaults. S is zero-extended to NDIG·DIGIT bits and A is zero-extended to the same width.
- FSM states: IDLE, CALC, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready: latch S and A, clear the borrow, set digit index = 0, go to CALC.
- CALC
  - Each cycle: diff = S[idx] − A[idx] − borrow. Write the DIGIT-bit result into the result register slice idx and register the borrow-out.
  - idx increments each cycle.
  - After slice NDIG−1, go to DONE.
- DONE
  - out_valid = 1.
  - out_b = result[WIDTH−1:0].
  - out_err = final borrow | (OR of result bits ≥ WIDTH).
  - On out_ready, return to IDLE.
- in_ready is 0 in CALC and DONE. Requests presented then are not accepted, and in_valid is ignored.
- In DONE, out_b and out_err hold stable until the out_ready handshake.
- Input operands are captured only at acceptance. Later changes to in_sum or in_a do not affect the transaction in flight.
- Asserting rst in any state, including mid-CALC, aborts the transaction and nothing is emitted.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - out_b = 0
  - out_err = 0
  - internal borrow, index and result registers = 0
- Latency:
  - The accepting edge is edge k.
  - The CALC slices are computed on edges k+1 … k+NDIG.
  - out_valid rises after edge k+NDIG, i.e. 4 cycles at the defaults.
- Handshake completes on an edge where out_valid & out_ready. out_valid is 0 after that edge and in_ready is 1.
- Minimum initiation interval is NDIG+2 cycles: accept, NDIG CALC cycles, and one DONE cycle with out_ready = 1.
- out_valid never depends combinationally on out_ready. in_ready is a registered state decode.
- Boundary cases:
  - S = A gives out_b = 0, out_err = 0.
  - S = 0, A = 0 gives out_b = 0, out_err = 0.
  - The borrow out of the top slice is the negative-result flag.

## Structure
- Shared package `sum_recover_pkg` holds:
  - the state enum (IDLE, CALC, DONE)
  - the localparam function computing NDIG from WIDTH and DIGIT
  - the default WIDTH and DIGIT constants, which the adder-side code shares
- Sub-module `digit_sub` is purely combinational:
  - inputs: DIGIT-bit a, DIGIT-bit b, borrow_in
  - outputs: DIGIT-bit diff, borrow_out
  - it is instantiated once and time-multiplexed across slices
- Top level holds the FSM, operand shift/index registers, result register and handshake logic.

## Test plan
- S = 13'h1000, A = 12'h001, out_ready held 1 → out_valid 4 cycles after accept, out_b = 12'hFFF, out_err = 0; in_ready returns to 1 one cycle later.
- S = 13'h1FFE, A = 12'hFFF → out_b = 12'hFFF, out_err = 0.
- S = 13'h0005, A = 12'h007 → out_b = 12'hFFE, out_err = 1 (negative). Then S = 13'h1FFF, A = 12'h000 → out_b = 12'hFFF, out_err = 1 (overflow).
- Backpressure:
  - Stimulus: out_ready = 0 for 10 cycles after out_valid rises, while in_valid stays high with new data.
  - Required: out_b and out_err stay stable and in_ready stays 0.
  - After out_ready = 1 for one cycle, the second request is accepted and produces its own correct result.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously 2 cycles into CALC.
  - Required, immediately: out_valid = 0, in_ready = 1, out_b = 0.
  - Then the next request S = 13'h0064, A = 12'h028 yields out_b = 12'h03C, out_err = 0.
- Randomized sweep against the reference model (S − A) over 1000 transactions, with random in_valid/out_ready gaps → no mismatches.
